// File: rtl/lsu_if.sv
// Bundle of the LSU request/response handshake and the data-memory bus.
// slave is the LSU's view; master is the execute stage plus data memory.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_load;
  logic [1:0]  mem_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport slave (
    input  req_valid, mem_load, mem_store, addr, wdata, rd,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport master (
    output req_valid, mem_load, mem_store, addr, wdata, rd,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding req/gnt/rvalid data-memory access.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_fail_nxt;
  logic        w_accept;
  logic        w_none;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_last;
  logic [2:0]  r_load;
  logic [1:0]  r_store;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [4:0]  r_resp_rd;

  // Access size: 0 byte, 1 half, 2 word.
  function automatic logic [1:0] size_of(input logic [2:0] ld, input logic [1:0] st);
    if (ld == 3'b001 || ld == 3'b100 || st == 2'b01)      return 2'd0;
    else if (ld == 3'b010 || ld == 3'b101 || st == 2'b10) return 2'd1;
    else                                                  return 2'd2;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] st, input logic [31:0] d);
    case (st)
      2'b01:   return {4{d[7:0]}};
      2'b10:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] ld, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (ld)
      3'b001:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b010:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_none    = (bus.mem_load == 3'b000) && (bus.mem_store == 2'b00);
  assign w_last    = (r_cnt == 8'(MAX_WAIT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] w_in_size;
  assign w_in_size  = size_of(bus.mem_load, bus.mem_store);
  assign w_misalign = ((w_in_size == 2'd1) && bus.addr[0]) ||
                      ((w_in_size == 2'd2) && (bus.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = ((bus.mem_load != 3'b000) && (bus.mem_store != 2'b00)) ||
                     (bus.mem_load == 3'b110) || (bus.mem_load == 3'b111) || w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A grant on the last budgeted cycle still completes a store, but a load
  // would need a further cycle for rvalid, so it is reported as timed out.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_none) begin
          if (w_illegal) begin
            w_state_nxt = S_RESP;
            w_fail_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.dmem_gnt) begin
          if (r_load == 3'b000) begin
            w_state_nxt = S_RESP;
          end else if (w_last) begin
            w_state_nxt = S_RESP;
            w_fail_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else if (w_last) begin
          w_state_nxt = S_RESP;
          w_fail_nxt  = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.dmem_rvalid) begin
          w_state_nxt = S_RESP;
        end else if (w_last) begin
          w_state_nxt = S_RESP;
          w_fail_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus fields are forced to zero outside REQ, so the unreset request
  // registers never reach the pins and stay stable while dmem_req is high.
  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_be    = '0;
    bus.dmem_wdata = '0;
    if (r_state == S_REQ) begin
      bus.dmem_req   = 1'b1;
      bus.dmem_we    = (r_store != 2'b00);
      bus.dmem_addr  = {r_addr[31:2], 2'b00};
      bus.dmem_be    = byte_en(size_of(r_load, r_store), r_addr[1:0]);
      bus.dmem_wdata = (r_store != 2'b00) ? store_rep(r_store, r_wdata) : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_load  <= bus.mem_load;
      r_store <= bus.mem_store;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_rd    <= bus.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_cnt <= '0;
    else if (r_state == S_IDLE)                         r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT)     r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
      if (w_state_nxt == S_RESP) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_fail_nxt;
        if (!w_fail_nxt && (r_state == S_WAIT)) begin
          r_resp_rdata <= load_align(r_load, r_addr[1:0], bus.dmem_rdata);
          r_resp_rd    <= r_rd;
        end
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_rd    = r_resp_rd;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written corner
// sequences and randomized accesses scored against a transaction-level model.
module tb_lsu;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();
  lsu #(.MAX_WAIT(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          dg;     // gnt on REQ cycle dg+1
    int          dr;     // rvalid dr cycles after gnt
    logic [31:0] word;
    int          k;      // cycle after acceptance carrying resp_valid
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  rrd;
    int          nreq;   // cycles with dmem_req high
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input int dg,
                              input int dr, input logic [31:0] word, input int k, input logic err,
                              input logic [31:0] rdata, input logic [4:0] rrd, input int nreq,
                              input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.rd = rd; v.dg = dg; v.dr = dr;
    v.word = word; v.k = k; v.err = err; v.rdata = rdata; v.rrd = rrd; v.nreq = nreq;
    v.be = be; v.wd = wd;
    return v;
  endfunction

  // Transaction-level reference: sizes in bytes, lanes and cycle budgets.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int n, lane, o, g, r;
    bit illegal, mis, ok;
    logic [31:0] sh;
    v = vi;
    illegal = (v.ld != 0 && v.st != 0) || (v.ld >= 6);
    n = (v.ld == 1 || v.ld == 4 || v.st == 1) ? 1 : (v.ld == 2 || v.ld == 5 || v.st == 2) ? 2 : 4;
    o = int'(v.addr[1:0]);
    mis = (n == 2 && (o % 2) == 1) || (n == 4 && o != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = illegal || mis;
`endif
    lane = (n == 1) ? o : (n == 2) ? (o / 2) * 2 : 0;
    v.be = 4'(((1 << n) - 1) << lane);
    v.wd = (n == 1) ? 32'(v.wdata[7:0]) * 32'h01010101 :
           (n == 2) ? 32'(v.wdata[15:0]) * 32'h00010001 : v.wdata;
    v.err = 1'b0; v.rdata = '0; v.rrd = '0;
    g = v.dg + 1;
    r = g + v.dr;
    if (illegal) begin
      v.k = 1; v.err = 1'b1; v.nreq = 0;
    end else begin
      v.nreq = (g < W) ? g : W;
      ok = (v.st != 0) ? (g <= W) : (r <= W);
      if (!ok) begin
        v.k = W + 1; v.err = 1'b1;
      end else begin
        v.k = ((v.st != 0) ? g : r) + 1;
        if (v.ld != 0) begin
          sh = v.word >> (8 * lane);
          case (n)
            1: v.rdata = (v.ld == 1) ? 32'($signed(sh[7:0])) : 32'(sh[7:0]);
            2: v.rdata = (v.ld == 2) ? 32'($signed(sh[15:0])) : 32'(sh[15:0]);
            default: v.rdata = v.word;
          endcase
          v.rrd = v.rd;
        end
      end
    end
    return v;
  endfunction

  task automatic run_access(input vec_t v, output int k, output logic err, output logic [31:0] rdata,
                            output logic [4:0] rrd, output int nreq, output logic busok);
    int gcyc;
    k = 0; err = 1'b0; rdata = '0; rrd = '0; nreq = 0; busok = 1'b1; gcyc = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.mem_load = v.ld; bus.mem_store = v.st;
    bus.addr = v.addr; bus.wdata = v.wdata; bus.rd = v.rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.mem_load = '0; bus.mem_store = '0;
    bus.addr = $urandom; bus.wdata = $urandom; bus.rd = 5'($urandom);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = $urandom;
      if (bus.resp_valid) begin
        k = c; err = bus.resp_err; rdata = bus.resp_rdata; rrd = bus.resp_rd;
        break;
      end
      if (bus.dmem_req) begin
        nreq++;
        if (bus.dmem_be !== v.be || bus.dmem_addr !== {v.addr[31:2], 2'b00} ||
            bus.dmem_we !== (v.st != 0) || (v.st != 0 && bus.dmem_wdata !== v.wd))
          busok = 1'b0;
        if (c == v.dg + 1) begin
          bus.dmem_gnt = 1'b1; gcyc = c;
        end
      end
      if (gcyc > 0 && c == gcyc + v.dr && v.ld != 0) begin
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = v.word;
      end
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    int k, nreq;
    logic err, busok;
    logic [31:0] rdata;
    logic [4:0] rrd;
    run_access(v, k, err, rdata, rrd, nreq, busok);
    chk({tag, ".resp_cycle"}, 32'(k), 32'(v.k));
    chk({tag, ".err"}, 32'(err), 32'(v.err));
    chk({tag, ".rdata"}, rdata, v.rdata);
    chk({tag, ".rd"}, 32'(rrd), 32'(v.rrd));
    chk({tag, ".req_cycles"}, 32'(nreq), 32'(nreq == 0 ? 0 : v.nreq));
    chk({tag, ".nreq_exp"}, 32'(nreq), 32'(v.nreq));
    chk({tag, ".bus"}, 32'(busok), 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    logic ok;
    vec_t v;
    bus.req_valid = 1'b0; bus.mem_load = '0; bus.mem_store = '0; bus.addr = '0;
    bus.wdata = '0; bus.rd = '0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    tbl[0]  = mk(3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 5'd5, 0, 1, 32'h0, 2, 1'b0, 32'h0, 5'd0, 1, 4'hF, 32'hDEADBEEF);
    tbl[1]  = mk(3'd0, 2'd1, 32'h103, 32'h000000A5, 5'd3, 0, 1, 32'h0, 2, 1'b0, 32'h0, 5'd0, 1, 4'h8, 32'hA5A5A5A5);
    tbl[2]  = mk(3'd0, 2'd2, 32'h102, 32'h00001234, 5'd3, 0, 1, 32'h0, 2, 1'b0, 32'h0, 5'd0, 1, 4'hC, 32'h12341234);
    tbl[3]  = mk(3'd1, 2'd0, 32'h201, 32'h0, 5'd7, 0, 1, 32'h80F08000, 3, 1'b0, 32'hFFFFFF80, 5'd7, 1, 4'h2, 32'h0);
    tbl[4]  = mk(3'd4, 2'd0, 32'h201, 32'h0, 5'd8, 0, 1, 32'h80F08000, 3, 1'b0, 32'h00000080, 5'd8, 1, 4'h2, 32'h0);
    tbl[5]  = mk(3'd2, 2'd0, 32'h202, 32'h0, 5'd9, 0, 1, 32'h80F08000, 3, 1'b0, 32'hFFFF80F0, 5'd9, 1, 4'hC, 32'h0);
    tbl[6]  = mk(3'd5, 2'd0, 32'h202, 32'h0, 5'd10, 0, 1, 32'h80F08000, 3, 1'b0, 32'h000080F0, 5'd10, 1, 4'hC, 32'h0);
    tbl[7]  = mk(3'd3, 2'd0, 32'h200, 32'h0, 5'd11, 1, 2, 32'h80F08000, 5, 1'b0, 32'h80F08000, 5'd11, 2, 4'hF, 32'h0);
    tbl[8]  = mk(3'd6, 2'd0, 32'h400, 32'h0, 5'd12, 0, 1, 32'h0, 1, 1'b1, 32'h0, 5'd0, 0, 4'h0, 32'h0);
    tbl[9]  = mk(3'd3, 2'd3, 32'h400, 32'h55, 5'd13, 0, 1, 32'h0, 1, 1'b1, 32'h0, 5'd0, 0, 4'h0, 32'h0);
    tbl[10] = mk(3'd0, 2'd3, 32'h500, 32'h77, 5'd1, 9, 1, 32'h0, 5, 1'b1, 32'h0, 5'd0, 4, 4'hF, 32'h77);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[11] = mk(3'd3, 2'd0, 32'h302, 32'h0, 5'd14, 0, 1, 32'h11223344, 1, 1'b1, 32'h0, 5'd0, 0, 4'h0, 32'h0);
`else
    tbl[11] = mk(3'd3, 2'd0, 32'h302, 32'h0, 5'd14, 0, 1, 32'h11223344, 3, 1'b0, 32'h11223344, 5'd14, 1, 4'hF, 32'h0);
`endif
    tbl[12] = mk(3'd3, 2'd0, 32'h504, 32'h0, 5'd2, 9, 1, 32'h0, 5, 1'b1, 32'h0, 5'd0, 4, 4'hF, 32'h0);

    // Reset state
    #12;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst.dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Late rvalid after the load timeout lands in IDLE and must be ignored
    @(negedge clk);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      if (bus.resp_valid || bus.dmem_req || !bus.req_ready) ok = 1'b0;
    end
    chk("late_rvalid.ignored", 32'(ok), 32'd1);

    // A request with neither code set produces nothing
    @(negedge clk);
    bus.req_valid = 1'b1; bus.mem_load = '0; bus.mem_store = '0; bus.addr = 32'h600;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.dmem_req || !bus.req_ready) ok = 1'b0;
    end
    chk("none.ignored", 32'(ok), 32'd1);

    // Reset while waiting for rvalid
    @(negedge clk);
    bus.req_valid = 1'b1; bus.mem_load = 3'd3; bus.mem_store = '0; bus.addr = 32'h40; bus.rd = 5'd6;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.mem_load = '0;
    @(negedge clk);
    chk("rstwait.T1_req", 32'(bus.dmem_req), 32'd1);
    chk("rstwait.T1_ready", 32'(bus.req_ready), 32'd0);
    bus.dmem_gnt = 1'b1;
    @(posedge clk);
    #1 bus.dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait.ready", 32'(bus.req_ready), 32'd1);
    chk("rstwait.outs", {bus.dmem_req, bus.dmem_we, bus.resp_valid, bus.resp_err, bus.dmem_be,
                         bus.resp_rd, 19'd0}, 32'd0);
    chk("rstwait.addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_rst", model(mk(3'd3, 2'd0, 32'h0, 32'h0, 5'd17, 0, 1, 32'hCAFEF00D,
                                0, 1'b0, 32'h0, 5'd0, 0, 4'h0, 32'h0)));

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      int kind;
      v = mk(3'd0, 2'd0, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(1, 3)), $urandom, 0, 1'b0, 32'h0, 5'd0, 0, 4'h0, 32'h0);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        v.ld = 3'($urandom_range(0, 7)); v.st = 2'($urandom_range(1, 3));
        if (v.ld < 6 && $urandom_range(0, 1) == 1) begin v.ld = 3'd6 + 3'($urandom_range(0, 1)); v.st = 2'd0; end
      end else if (kind < 6) begin
        v.ld = 3'($urandom_range(1, 5));
      end else begin
        v.st = 2'($urandom_range(1, 3));
      end
      apply($sformatf("rnd%0d", i), model(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
